fp_minmax_reduce: RTL and testbench

FP_MINMAX_REDUCE -- requirements
Module: fp_minmax_reduce

---
 rtl/fp_minmax_pkg.sv | 29 ++
 rtl/fp_minmax_cmp.sv | 78 +++++++
 rtl/fp_minmax_reduce.sv | 177 +++++++++++++++++
 tb/tb_fp_minmax_reduce.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_minmax_pkg.sv
// Shared constants, class-bit positions and FSM states for the FP min/max stream reducer.
package fp_minmax_pkg;

    localparam int SNAN_BIT = 8;
    localparam int QNAN_BIT = 9;
    localparam int NV_BIT   = 4;

    localparam logic [63:0] QNAN64 = 64'h7ff8000000000000;
    localparam logic [31:0] QNAN32 = 32'h7fc00000;

    localparam logic [2:0] RM_MIN = 3'd0;
    localparam logic [2:0] RM_MAX = 3'd1;

    localparam logic [1:0] FMT_S = 2'd0;
    localparam logic [1:0] FMT_D = 2'd1;

    localparam logic [9:0] CLASS_QNAN = 10'b10_0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic is_nan(input logic [9:0] cls);
        return cls[SNAN_BIT] | cls[QNAN_BIT];
    endfunction

endpackage

// File: rtl/fp_minmax_cmp.sv
// Combinational pairwise min/max of accumulator (op1) and new element (op2),
// with NaN propagation rules and the invalid (sNaN) flag.
module fp_minmax_cmp
    import fp_minmax_pkg::*;
#(
    parameter int FLEN = 64
) (
    input  logic [FLEN-1:0] op1_data,
    input  logic [FLEN-1:0] op2_data,
    input  logic [FLEN:0]   op1_ext,
    input  logic [FLEN:0]   op2_ext,
    input  logic [9:0]      op1_class,
    input  logic [9:0]      op2_class,
    input  logic [1:0]      fmt,
    input  logic [2:0]      rm,
    output logic [FLEN-1:0] result,
    output logic            nan_out,
    output logic            nv,
    output logic            sel2
);

    logic            nan1;
    logic            nan2;
    logic            sign1;
    logic            sign2;
    logic [FLEN-1:0] mag1;
    logic [FLEN-1:0] mag2;
    logic            keys_eq;
    logic            op1_lt;
    logic [63:0]     qnan_wide;
    logic            unused_class;

    assign unused_class = ^{op1_class[7:0], op2_class[7:0]};

    always_comb begin
        nan1    = is_nan(op1_class);
        nan2    = is_nan(op2_class);
        sign1   = op1_ext[FLEN];
        sign2   = op2_ext[FLEN];
        mag1    = op1_ext[FLEN-1:0];
        mag2    = op2_ext[FLEN-1:0];
        keys_eq = (op1_ext == op2_ext);

        // Sign-magnitude ordering; a set sign bit orders -0 below +0.
        if (sign1 != sign2) begin
            op1_lt = sign1;
        end else if (!sign1) begin
            op1_lt = (mag1 < mag2);
        end else begin
            op1_lt = (mag1 > mag2);
        end

        if (rm == RM_MAX) begin
            sel2 = op1_lt | (keys_eq & ~sign1);
        end else begin
            sel2 = (~op1_lt & ~keys_eq) | (keys_eq & sign1);
        end

        nan_out = 1'b0;
        if (nan1 && nan2) begin
            nan_out = 1'b1;
            sel2    = 1'b0;
        end else if (nan1) begin
            sel2 = 1'b1;
        end else if (nan2) begin
            sel2 = 1'b0;
        end

        qnan_wide = (fmt == FMT_D) ? QNAN64 : {32'h0, QNAN32};
        if (FLEN == 32) begin
            qnan_wide = {32'h0, QNAN32};
        end

        result = nan_out ? qnan_wide[FLEN-1:0] : (sel2 ? op2_data : op1_data);
        nv     = op1_class[SNAN_BIT] | op2_class[SNAN_BIT];
    end

endmodule

// File: rtl/fp_minmax_reduce.sv
// Streaming FP min/max reduction with sticky NV flag and saturating element count.
// Optional out_index port (position of the held result) enabled by FP_MINMAX_INDEX_EN.
//   state | meaning
//   IDLE  | waiting for the first element of a stream
//   ACCUM | folding further elements into the accumulator
//   DONE  | result presented, waiting for out_ready
module fp_minmax_reduce
    import fp_minmax_pkg::*;
#(
    parameter int FLEN  = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FLEN-1:0]  in_data,
    input  logic [FLEN:0]    in_ext,
    input  logic [9:0]       in_class,
    input  logic [1:0]       in_fmt,
    input  logic [2:0]       in_rm,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FLEN-1:0]  out_result,
    output logic [4:0]       out_flags,
    output logic [CNT_W-1:0] out_count
`ifdef FP_MINMAX_INDEX_EN
    ,
    output logic [CNT_W-1:0] out_index
`endif
);

    state_e            state_q,     state_d;
    logic [FLEN-1:0]   acc_data_q,  acc_data_d;
    logic [FLEN:0]     acc_ext_q,   acc_ext_d;
    logic [9:0]        acc_class_q, acc_class_d;
    logic [1:0]        fmt_q,       fmt_d;
    logic [2:0]        rm_q,        rm_d;
    logic              nv_q,        nv_d;
    logic [CNT_W-1:0]  count_q,     count_d;
`ifdef FP_MINMAX_INDEX_EN
    logic [CNT_W-1:0]  idx_q,       idx_d;
`endif

    logic              accept;
    logic [CNT_W-1:0]  count_inc;
    logic [FLEN-1:0]   cmp_result;
    logic              cmp_nan;
    logic              cmp_nv;
    logic              cmp_sel2;

    fp_minmax_cmp #(
        .FLEN (FLEN)
    ) u_cmp (
        .op1_data  (acc_data_q),
        .op2_data  (in_data),
        .op1_ext   (acc_ext_q),
        .op2_ext   (in_ext),
        .op1_class (acc_class_q),
        .op2_class (in_class),
        .fmt       (fmt_q),
        .rm        (rm_q),
        .result    (cmp_result),
        .nan_out   (cmp_nan),
        .nv        (cmp_nv),
        .sel2      (cmp_sel2)
    );

    always_comb begin
        state_d     = state_q;
        acc_data_d  = acc_data_q;
        acc_ext_d   = acc_ext_q;
        acc_class_d = acc_class_q;
        fmt_d       = fmt_q;
        rm_d        = rm_q;
        nv_d        = nv_q;
        count_d     = count_q;
`ifdef FP_MINMAX_INDEX_EN
        idx_d       = idx_q;
`endif

        in_ready  = (state_q != DONE);
        out_valid = (state_q == DONE);
        accept    = in_valid && in_ready;
        count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_data_d = in_data;
                    acc_ext_d  = in_ext;
                    // A held NaN is demoted to quiet so any later number replaces it.
                    acc_class_d = is_nan(in_class) ? CLASS_QNAN : in_class;
                    fmt_d      = in_fmt;
                    rm_d       = in_rm;
                    nv_d       = in_class[SNAN_BIT];
                    count_d    = count_inc;
`ifdef FP_MINMAX_INDEX_EN
                    idx_d      = '0;
`endif
                    state_d    = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_data_d = cmp_result;
                    if (cmp_nan) begin
                        acc_ext_d   = '0;
                        acc_class_d = CLASS_QNAN;
                    end else if (cmp_sel2) begin
                        acc_ext_d   = in_ext;
                        acc_class_d = in_class;
                    end
                    nv_d    = nv_q | cmp_nv;
                    count_d = count_inc;
`ifdef FP_MINMAX_INDEX_EN
                    if (cmp_nan) begin
                        idx_d = '0;
                    end else if (cmp_sel2) begin
                        idx_d = count_q;
                    end
`endif
                    if (in_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    count_d = '0;
                    nv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_data_q  <= '0;
            acc_ext_q   <= '0;
            acc_class_q <= '0;
            fmt_q       <= '0;
            rm_q        <= '0;
            nv_q        <= 1'b0;
            count_q     <= '0;
`ifdef FP_MINMAX_INDEX_EN
            idx_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_data_q  <= acc_data_d;
            acc_ext_q   <= acc_ext_d;
            acc_class_q <= acc_class_d;
            fmt_q       <= fmt_d;
            rm_q        <= rm_d;
            nv_q        <= nv_d;
            count_q     <= count_d;
`ifdef FP_MINMAX_INDEX_EN
            idx_q       <= idx_d;
`endif
        end
    end

    assign out_result = acc_data_q;
    assign out_flags  = {nv_q, 4'b0000};
    assign out_count  = count_q;
`ifdef FP_MINMAX_INDEX_EN
    assign out_index  = idx_q;
`endif

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Self-checking bench for fp_minmax_reduce: directed streams plus random streams
// scored against an order-based reference model.
module tb_fp_minmax_reduce;

    localparam int FLEN  = 64;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [FLEN-1:0]  in_data;
    logic [FLEN:0]    in_ext;
    logic [9:0]       in_class;
    logic [1:0]       in_fmt;
    logic [2:0]       in_rm;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [FLEN-1:0]  out_result;
    logic [4:0]       out_flags;
    logic [CNT_W-1:0] out_count;
`ifdef FP_MINMAX_INDEX_EN
    logic [CNT_W-1:0] out_index;
`endif

    fp_minmax_reduce #(.FLEN(FLEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ext     (in_ext),
        .in_class   (in_class),
        .in_fmt     (in_fmt),
        .in_rm      (in_rm),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_count  (out_count)
`ifdef FP_MINMAX_INDEX_EN
        ,
        .out_index  (out_index)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        bit          sign;
        int unsigned mag;
        bit          snan;
        bit          qnan;
    } elem_t;

    elem_t       q[$];
    logic [1:0]  s_fmt;
    logic [2:0]  s_rm;
    int          checks = 0;
    int          passed = 0;
    logic [63:0] exp_res;
    logic [4:0]  exp_flags;
    logic [7:0]  exp_cnt;
    logic [7:0]  exp_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic longint ord(input elem_t e);
        return e.sign ? (-longint'(e.mag) - 1) : longint'(e.mag);
    endfunction

    // Does candidate e displace current best b? Equal keys: MIN prefers the later
    // element only when negative, MAX only when positive.
    function automatic bit take(input elem_t e, input elem_t b);
        longint o  = ord(e);
        longint ob = ord(b);
        if (s_rm == 3'd1) return (o > ob) || (o == ob && !e.sign);
        return (o < ob) || (o == ob && e.sign);
    endfunction

    task automatic model();
        int n    = q.size();
        int best = -1;
        bit nv   = 0;
        foreach (q[i]) nv |= q[i].snan;
        exp_flags = {nv, 4'b0000};
        exp_cnt   = (n > 255) ? 8'd255 : 8'(n);
        if (n == 1) begin
            exp_res = q[0].data;
            exp_idx = 8'd0;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (q[i].snan || q[i].qnan) continue;
                if (best < 0) best = i;
                else if (take(q[i], q[best])) best = i;
            end
            if (best < 0) begin
                exp_res = (s_fmt == 2'd1) ? 64'h7ff8000000000000 : 64'h000000007fc00000;
                exp_idx = 8'd0;
            end else begin
                exp_res = q[best].data;
                exp_idx = (best > 255) ? 8'd255 : 8'(best);
            end
        end
    endtask

    task automatic add(input logic [63:0] d, input bit s, input int unsigned m,
                       input bit sn, input bit qn);
        elem_t e;
        e.data = d; e.sign = s; e.mag = m; e.snan = sn; e.qnan = qn;
        q.push_back(e);
    endtask

    task automatic drive_elem(input elem_t e, input bit last);
        logic [19:0] m20;
        m20      = e.mag[19:0];
        in_data  = e.data;
        in_ext   = {e.sign, 44'b0, m20};
        in_class = e.snan ? 10'h100 : (e.qnan ? 10'h200 : 10'h040);
        in_last  = last;
    endtask

    // Streams q without a gap; elements after the first carry junk fmt/rm.
    task automatic send_elems(input string tag, input bit mark_last);
        int n = q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            drive_elem(q[i], mark_last && (i == n - 1));
            in_fmt = (i == 0) ? s_fmt : 2'($urandom);
            in_rm  = (i == 0) ? s_rm  : 3'($urandom);
            if (i == 0 || i == n - 1) begin
                chk({tag, ":in_ready"}, 64'(in_ready), 64'd1);
                chk({tag, ":no_early_valid"}, 64'(out_valid), 64'd0);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_stream(input string tag);
        send_elems(tag, 1'b1);
        chk({tag, ":valid_latency"}, 64'(out_valid), 64'd1);
        model();
        chk({tag, ":result"}, out_result, exp_res);
        chk({tag, ":flags"}, 64'(out_flags), 64'(exp_flags));
        chk({tag, ":count"}, 64'(out_count), 64'(exp_cnt));
`ifdef FP_MINMAX_INDEX_EN
        chk({tag, ":index"}, 64'(out_index), 64'(exp_idx));
`endif
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ":valid_cleared"}, 64'(out_valid), 64'd0);
        chk({tag, ":ready_again"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
        in_data = '0; in_ext = '0; in_class = '0; in_fmt = '0; in_rm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset:out_valid", 64'(out_valid), 64'd0);
        chk("reset:out_result", out_result, 64'd0);
        chk("reset:out_flags", 64'(out_flags), 64'd0);
        chk("reset:out_count", 64'(out_count), 64'd0);
        chk("reset:in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // MAX, double: +10, +20, -5
        q.delete(); s_fmt = 2'd1; s_rm = 3'd1;
        add(64'h1111, 0, 10, 0, 0); add(64'h2222, 0, 20, 0, 0); add(64'h3333, 1, 5, 0, 0);
        run_stream("max3");
        chk("max3:payload", out_result, 64'h2222);
        consume("max3");

        // MIN, equal negative keys take the later element
        q.delete(); s_fmt = 2'd1; s_rm = 3'd0;
        add(64'hA, 1, 33, 0, 0); add(64'hB, 1, 33, 0, 0);
        run_stream("min_tie_neg");
        chk("min_tie_neg:payload", out_result, 64'hB);
        consume("min_tie_neg");

        // +0 vs -0
        q.delete(); s_rm = 3'd0;
        add(64'h0, 0, 0, 0, 0); add(64'h8000000000000000, 1, 0, 0, 0);
        run_stream("min_zero");
        chk("min_zero:payload", out_result, 64'h8000000000000000);
        consume("min_zero");
        s_rm = 3'd1;
        run_stream("max_zero");
        chk("max_zero:payload", out_result, 64'h0);
        consume("max_zero");

        // Single-precision NaN handling
        q.delete(); s_fmt = 2'd0; s_rm = 3'd1;
        add(64'h7fa00000, 0, 1, 1, 0); add(64'h7fc12345, 0, 2, 0, 1);
        run_stream("snan_qnan");
        chk("snan_qnan:canon", out_result, 64'h000000007fc00000);
        chk("snan_qnan:nv", 64'(out_flags), 64'h10);
        consume("snan_qnan");
        q.delete();
        add(64'h7fa00000, 0, 1, 1, 0); add(64'h7777, 0, 7, 0, 0);
        run_stream("snan_num");
        chk("snan_num:payload", out_result, 64'h7777);
        consume("snan_num");

        // Single sNaN element is returned unchanged
        q.delete(); s_fmt = 2'd1; s_rm = 3'd0;
        add(64'h7ff4000000000001, 0, 3, 1, 0);
        run_stream("single_snan");
        consume("single_snan");

        // Backpressure in DONE, with junk offered on the input
        q.delete(); s_rm = 3'd0;
        add(64'h55, 0, 4, 0, 0); add(64'h66, 1, 2, 0, 0); add(64'h77, 0, 1, 0, 0);
        run_stream("bp");
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_last = 1'b1;
            in_data = {$urandom, $urandom}; in_ext = '0; in_class = 10'h040;
            @(negedge clk);
            chk("bp:in_ready", 64'(in_ready), 64'd0);
            chk("bp:out_valid", 64'(out_valid), 64'd1);
            chk("bp:hold_result", out_result, exp_res);
            chk("bp:hold_count", 64'(out_count), 64'(exp_cnt));
        end
        in_valid = 1'b0; in_last = 1'b0;
        consume("bp");

        // Reset mid-stream after two elements
        q.delete(); s_rm = 3'd1;
        add(64'h9, 0, 5, 1, 0); add(64'hA, 0, 6, 0, 0);
        send_elems("midrst", 1'b0);
        chk("midrst:count_before", 64'(out_count), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst:out_valid", 64'(out_valid), 64'd0);
        chk("midrst:out_count", 64'(out_count), 64'd0);
        chk("midrst:out_flags", 64'(out_flags), 64'd0);
        chk("midrst:in_ready", 64'(in_ready), 64'd1);

        // Reset while in DONE
        q.delete();
        add(64'hC, 0, 1, 0, 0);
        run_stream("donerst");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("donerst:out_valid", 64'(out_valid), 64'd0);
        chk("donerst:out_count", 64'(out_count), 64'd0);

        // Random streams
        for (int s = 0; s < 25; s++) begin
            int n;
            q.delete();
            s_fmt = 2'($urandom_range(0, 1));
            s_rm  = 3'($urandom_range(0, 1));
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                int r = $urandom_range(0, 9);
                add({$urandom, $urandom}, 1'($urandom), $urandom_range(0, 7), r == 0, r == 1);
            end
            run_stream($sformatf("rand%0d", s));
            consume($sformatf("rand%0d", s));
        end

        // Count saturation: clear winner first, then 299 smaller keys
        q.delete(); s_fmt = 2'd1; s_rm = 3'd1;
        add(64'hFEED, 0, 100, 0, 0);
        for (int i = 1; i < 300; i++) add({$urandom, $urandom}, 1'($urandom), $urandom_range(0, 7), 0, 0);
        run_stream("sat");
        chk("sat:count255", 64'(out_count), 64'd255);
        consume("sat");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
